// File: rtl/led_display_package.sv
// Shared constants and types for the LED panel capture blocks.
//   DEFAULT_NUM_COLS / DEFAULT_NUM_ROWS : default panel geometry
//   err_flags_t                         : sticky error flags (length, overflow, blank)
package led_display_package;

   localparam int unsigned DEFAULT_NUM_COLS = 64;
   localparam int unsigned DEFAULT_NUM_ROWS = 32;

   typedef struct packed {
      logic len;
      logic ovf;
      logic blank;
   } err_flags_t;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser with registered rising-edge detection.
//   clk, n_reset : system clock, synchronous active-low reset
//   d_in         : asynchronous inputs
//   det_o        : per bit, a one-cycle rising-edge pulse, or (where LEVEL_MASK
//                  is set) the synchronised level aligned with those pulses
module sync_edge_det #(
   parameter int unsigned      WIDTH      = 1,
   parameter logic [WIDTH-1:0] LEVEL_MASK = '0
) (
   input  logic             clk,
   input  logic             n_reset,
   input  logic [WIDTH-1:0] d_in,
   output logic [WIDTH-1:0] det_o
);

   logic [WIDTH-1:0] meta_q, meta_d;
   logic [WIDTH-1:0] sync_q, sync_d;
   logic [WIDTH-1:0] dly_q, dly_d;
   logic [WIDTH-1:0] rise_q, rise_d;

   always_comb begin
      meta_d = d_in;
      sync_d = meta_q;
      dly_d  = sync_q;
      rise_d = sync_q & ~dly_q;
   end

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         meta_q <= '0;
         sync_q <= '0;
         dly_q  <= '0;
         rise_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         dly_q  <= dly_d;
         rise_q <= rise_d;
      end
   end

   // dly_q holds the synchronised level that rise_q was computed from, so a
   // level bit and a pulse bit sampled together describe the same instant.
   assign det_o = (LEVEL_MASK & dly_q) | (~LEVEL_MASK & rise_q);

endmodule

// File: rtl/panel_row_capture.sv
// Captures one LED-panel row from the shift/latch interface into parallel form.
//   clk, n_reset        : system clock, synchronous active-low reset
//   bclk, le_in, oe_in  : panel shift clock, latch enable, active-low output enable
//   rgb_top, rgb_bot    : per-chain {b,g,r} serial data
//   addr_in             : row address
//   row_top, row_bot    : captured row, field (chain*3+colour), column 0 at field MSB
//   row_addr, row_first : address of captured row, address is zero
//   row_valid/row_ready : output handshake
//   err_len/ovf/blank   : sticky errors; row_count: accepted rows; clr_status clears both
module panel_row_capture
   import led_display_package::*;
#(
   parameter int unsigned NUM_COLS   = DEFAULT_NUM_COLS,
   parameter int unsigned NUM_ROWS   = DEFAULT_NUM_ROWS,
   parameter int unsigned NUM_CHAINS = 1,
   parameter int unsigned ADDR_W     = $clog2(NUM_ROWS / 2)
) (
   input  logic                             clk,
   input  logic                             n_reset,
   input  logic                             bclk,
   input  logic [3*NUM_CHAINS-1:0]          rgb_top,
   input  logic [3*NUM_CHAINS-1:0]          rgb_bot,
   input  logic [ADDR_W-1:0]                addr_in,
   input  logic                             oe_in,
   input  logic                             le_in,
   output logic [3*NUM_COLS*NUM_CHAINS-1:0] row_top,
   output logic [3*NUM_COLS*NUM_CHAINS-1:0] row_bot,
   output logic [ADDR_W-1:0]                row_addr,
   output logic                             row_first,
   output logic                             row_valid,
   input  logic                             row_ready,
   output logic                             err_len,
   output logic                             err_ovf,
   output logic                             err_blank,
   output logic [15:0]                      row_count,
   input  logic                             clr_status
);

   localparam int unsigned NF    = 3 * NUM_CHAINS;
   localparam int unsigned ROW_W = NF * NUM_COLS;
   localparam int unsigned CNT_W = $clog2(NUM_COLS + 2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_COLS);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(NUM_COLS + 1);

   logic [2:0] ctl_det;
   logic       bclk_rise, le_rise, oe_low;

   logic [NF-1:0]     top_meta_q, top_meta_d, top_sync_q, top_sync_d;
   logic [NF-1:0]     bot_meta_q, bot_meta_d, bot_sync_q, bot_sync_d;
   logic [ADDR_W-1:0] addr_meta_q, addr_meta_d, addr_sync_q, addr_sync_d;
   logic [ROW_W-1:0]  sh_top_q, sh_top_d, sh_bot_q, sh_bot_d;
   logic [ROW_W-1:0]  row_top_q, row_top_d, row_bot_q, row_bot_d;
   logic [CNT_W-1:0]  col_cnt_q, col_cnt_d;
   logic [ADDR_W-1:0] row_addr_q, row_addr_d;
   logic              row_first_q, row_first_d;
   logic              row_valid_q, row_valid_d;
   logic [15:0]       row_count_q, row_count_d;
   err_flags_t        err_q, err_d;

   logic [CNT_W-1:0]  col_next;
   logic              handshake;

   // bclk and le_in are edge-detected; oe_in is only needed as a level.
   sync_edge_det #(
      .WIDTH     (3),
      .LEVEL_MASK(3'b100)
   ) u_ctl_sync (
      .clk    (clk),
      .n_reset(n_reset),
      .d_in   ({oe_in, le_in, bclk}),
      .det_o  (ctl_det)
   );

   assign bclk_rise = ctl_det[0];
   assign le_rise   = ctl_det[1];
   assign oe_low    = ~ctl_det[2];

   always_comb begin
      top_meta_d  = rgb_top;
      bot_meta_d  = rgb_bot;
      addr_meta_d = addr_in;
      top_sync_d  = top_meta_q;
      bot_sync_d  = bot_meta_q;
      addr_sync_d = addr_meta_q;

      sh_top_d    = sh_top_q;
      sh_bot_d    = sh_bot_q;
      col_next    = col_cnt_q;
      row_top_d   = row_top_q;
      row_bot_d   = row_bot_q;
      row_addr_d  = row_addr_q;
      row_first_d = row_first_q;

      handshake   = row_valid_q & row_ready;
      row_valid_d = row_valid_q & ~handshake;

      // Clearing is applied first so same-cycle events still land.
      err_d       = clr_status ? '0 : err_q;
      row_count_d = clr_status ? '0 : row_count_q;

      if (bclk_rise) begin
         for (int unsigned f = 0; f < NF; f++) begin
            sh_top_d[f*NUM_COLS +: NUM_COLS] = {sh_top_q[f*NUM_COLS +: NUM_COLS-1], top_sync_q[f]};
            sh_bot_d[f*NUM_COLS +: NUM_COLS] = {sh_bot_q[f*NUM_COLS +: NUM_COLS-1], bot_sync_q[f]};
         end
         if (col_cnt_q != CNT_SAT) begin
            col_next = col_cnt_q + 1'b1;
         end
      end

      col_cnt_d = col_next;

      // Acceptance looks at the post-shift count and data, so a coincident
      // final bclk edge still completes the row.
      if (le_rise) begin
         col_cnt_d = '0;
         if (oe_low) begin
            err_d.blank = 1'b1;
         end
         if (col_next == CNT_FULL) begin
            if (row_valid_q && !handshake) begin
               err_d.ovf = 1'b1;
            end else begin
               row_top_d   = sh_top_d;
               row_bot_d   = sh_bot_d;
               row_addr_d  = addr_sync_q;
               row_first_d = (addr_sync_q == '0);
               row_valid_d = 1'b1;
               row_count_d = row_count_d + 16'd1;
            end
         end else begin
            err_d.len = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         top_meta_q  <= '0;
         bot_meta_q  <= '0;
         addr_meta_q <= '0;
         top_sync_q  <= '0;
         bot_sync_q  <= '0;
         addr_sync_q <= '0;
         sh_top_q    <= '0;
         sh_bot_q    <= '0;
         col_cnt_q   <= '0;
         row_top_q   <= '0;
         row_bot_q   <= '0;
         row_addr_q  <= '0;
         row_first_q <= 1'b0;
         row_valid_q <= 1'b0;
         row_count_q <= '0;
         err_q       <= '0;
      end else begin
         top_meta_q  <= top_meta_d;
         bot_meta_q  <= bot_meta_d;
         addr_meta_q <= addr_meta_d;
         top_sync_q  <= top_sync_d;
         bot_sync_q  <= bot_sync_d;
         addr_sync_q <= addr_sync_d;
         sh_top_q    <= sh_top_d;
         sh_bot_q    <= sh_bot_d;
         col_cnt_q   <= col_cnt_d;
         row_top_q   <= row_top_d;
         row_bot_q   <= row_bot_d;
         row_addr_q  <= row_addr_d;
         row_first_q <= row_first_d;
         row_valid_q <= row_valid_d;
         row_count_q <= row_count_d;
         err_q       <= err_d;
      end
   end

   assign row_top   = row_top_q;
   assign row_bot   = row_bot_q;
   assign row_addr  = row_addr_q;
   assign row_first = row_first_q;
   assign row_valid = row_valid_q;
   assign row_count = row_count_q;
   assign err_len   = err_q.len;
   assign err_ovf   = err_q.ovf;
   assign err_blank = err_q.blank;

endmodule

// File: tb/tb_panel_row_capture.sv
// Directed bench for panel_row_capture with two chains of 64 columns.
module tb_panel_row_capture;

   localparam int W = 384;

   logic           clk = 1'b0;
   logic           n_reset = 1'b0;
   logic           bclk = 1'b0;
   logic [5:0]     rgb_top = '0;
   logic [5:0]     rgb_bot = '0;
   logic [3:0]     addr_in = '0;
   logic           oe_in = 1'b1;
   logic           le_in = 1'b0;
   logic [W-1:0]   row_top, row_bot;
   logic [3:0]     row_addr;
   logic           row_first, row_valid;
   logic           row_ready = 1'b0;
   logic           err_len, err_ovf, err_blank;
   logic [15:0]    row_count;
   logic           clr_status = 1'b0;

   int nvec = 0;
   int nmis = 0;
   logic v_k2, v_k3;

   panel_row_capture #(
      .NUM_COLS  (64),
      .NUM_ROWS  (32),
      .NUM_CHAINS(2)
   ) dut (
      .clk       (clk),
      .n_reset   (n_reset),
      .bclk      (bclk),
      .rgb_top   (rgb_top),
      .rgb_bot   (rgb_bot),
      .addr_in   (addr_in),
      .oe_in     (oe_in),
      .le_in     (le_in),
      .row_top   (row_top),
      .row_bot   (row_bot),
      .row_addr  (row_addr),
      .row_first (row_first),
      .row_valid (row_valid),
      .row_ready (row_ready),
      .err_len   (err_len),
      .err_ovf   (err_ovf),
      .err_blank (err_blank),
      .row_count (row_count),
      .clr_status(clr_status)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          npulse;
      logic [5:0]  c0t, rt, c0b, rb;
      logic [3:0]  addr;
      logic        oe;
      logic        acc;
      logic        first;
      logic [15:0] cnt;
      logic        len;
      logic        blank;
   } vec_t;

   vec_t tbl [6];

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Column 0 carries c0, all later columns carry r; field f = chain*3+colour.
   function automatic logic [W-1:0] exp_row(input logic [5:0] c0, input logic [5:0] r);
      logic [W-1:0] e;
      e = '0;
      for (int f = 0; f < 6; f++) begin
         for (int i = 0; i < 63; i++) e[f*64+i] = r[f];
         e[f*64+63] = c0[f];
      end
      return e;
   endfunction

   task automatic pulses(input int n, input logic [5:0] c0t, input logic [5:0] rt,
                         input logic [5:0] c0b, input logic [5:0] rb);
      for (int p = 0; p < n; p++) begin
         @(negedge clk);
         rgb_top = (p == 0) ? c0t : rt;
         rgb_bot = (p == 0) ? c0b : rb;
         repeat (3) @(negedge clk);
         bclk = 1'b1;
         repeat (4) @(negedge clk);
         bclk = 1'b0;
      end
   endtask

   // le_in rises just before edge k; row_valid sampled after k+2 and k+3.
   task automatic send_row(input int n, input logic [5:0] c0t, input logic [5:0] rt,
                           input logic [5:0] c0b, input logic [5:0] rb, input logic [3:0] addr,
                           input logic oe, input logic ready_acc, input logic clr_acc);
      addr_in = addr;
      oe_in   = oe;
      pulses(n, c0t, rt, c0b, rb);
      repeat (4) @(negedge clk);
      le_in = 1'b1;
      repeat (3) @(posedge clk);
      #1 v_k2 = row_valid;
      @(negedge clk);
      if (ready_acc) row_ready = 1'b1;
      if (clr_acc) clr_status = 1'b1;
      @(posedge clk);
      #1 v_k3 = row_valid;
      @(negedge clk);
      row_ready  = 1'b0;
      clr_status = 1'b0;
      repeat (3) @(negedge clk);
      le_in = 1'b0;
      repeat (6) @(negedge clk);
      oe_in   = 1'b1;
      rgb_top = '0;
      rgb_bot = '0;
   endtask

   task automatic ready_pulse();
      @(negedge clk);
      row_ready = 1'b1;
      @(negedge clk);
      row_ready = 1'b0;
   endtask

   task automatic clr_pulse();
      @(negedge clk);
      clr_status = 1'b1;
      @(negedge clk);
      clr_status = 1'b0;
   endtask

   initial begin
      tbl[0] = '{64, 6'h01, 6'h00, 6'h00, 6'h00, 4'd5,  1'b1, 1'b1, 1'b0, 16'd1, 1'b0, 1'b0};
      tbl[1] = '{63, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 4'd2,  1'b1, 1'b0, 1'b0, 16'd1, 1'b1, 1'b0};
      tbl[2] = '{64, 6'h02, 6'h00, 6'h04, 6'h04, 4'd9,  1'b1, 1'b1, 1'b0, 16'd2, 1'b1, 1'b0};
      tbl[3] = '{64, 6'h00, 6'h00, 6'h20, 6'h20, 4'd0,  1'b1, 1'b1, 1'b1, 16'd3, 1'b1, 1'b0};
      tbl[4] = '{66, 6'h07, 6'h07, 6'h00, 6'h00, 4'd1,  1'b1, 1'b0, 1'b0, 16'd3, 1'b1, 1'b0};
      tbl[5] = '{64, 6'h00, 6'h12, 6'h09, 6'h00, 4'd15, 1'b0, 1'b1, 1'b0, 16'd4, 1'b1, 1'b1};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_valid", row_valid, 0);
      check("rst_count", row_count, 0);
      check("rst_errs",  {err_len, err_ovf, err_blank}, 0);
      check("rst_top",   row_top, 0);
      n_reset = 1'b1;
      repeat (4) @(negedge clk);

      // Table: each accepted row is checked then handed off
      for (int v = 0; v < 6; v++) begin
         send_row(tbl[v].npulse, tbl[v].c0t, tbl[v].rt, tbl[v].c0b, tbl[v].rb,
                  tbl[v].addr, tbl[v].oe, 1'b0, 1'b0);
         check($sformatf("v%0d_lat_k2", v), v_k2, 0);
         check($sformatf("v%0d_valid_k3", v), v_k3, tbl[v].acc);
         if (tbl[v].acc) begin
            check($sformatf("v%0d_top", v), row_top, exp_row(tbl[v].c0t, tbl[v].rt));
            check($sformatf("v%0d_bot", v), row_bot, exp_row(tbl[v].c0b, tbl[v].rb));
            check($sformatf("v%0d_addr", v), row_addr, tbl[v].addr);
            check($sformatf("v%0d_first", v), row_first, tbl[v].first);
         end
         check($sformatf("v%0d_count", v), row_count, tbl[v].cnt);
         check($sformatf("v%0d_len", v), err_len, tbl[v].len);
         check($sformatf("v%0d_blank", v), err_blank, tbl[v].blank);
         check($sformatf("v%0d_ovf", v), err_ovf, 0);
         if (tbl[v].acc) begin
            ready_pulse();
            check($sformatf("v%0d_released", v), row_valid, 0);
         end
      end
      check("red_field", row_top[63:0], 0);

      // clr_status clears sticky flags and the counter
      clr_pulse();
      check("clr_errs",  {err_len, err_ovf, err_blank}, 0);
      check("clr_count", row_count, 0);

      // Overflow: second row dropped while the first is held
      send_row(64, 6'h01, 6'h01, 6'h00, 6'h00, 4'd3, 1'b1, 1'b0, 1'b0);
      check("ovf_first_valid", v_k3, 1);
      send_row(64, 6'h02, 6'h02, 6'h00, 6'h00, 4'd7, 1'b1, 1'b0, 1'b0);
      check("ovf_still_valid", v_k3, 1);
      check("ovf_top_kept",  row_top, exp_row(6'h01, 6'h01));
      check("ovf_addr_kept", row_addr, 4'd3);
      check("ovf_flag",      err_ovf, 1);
      check("ovf_count",     row_count, 1);
      ready_pulse();
      check("ovf_released",  row_valid, 0);

      // Acceptance coinciding with a handshake replaces the held row
      clr_pulse();
      send_row(64, 6'h04, 6'h04, 6'h00, 6'h00, 4'd4, 1'b1, 1'b0, 1'b0);
      send_row(64, 6'h00, 6'h00, 6'h08, 6'h08, 4'd6, 1'b1, 1'b1, 1'b0);
      check("hs_valid_k3", v_k3, 1);
      check("hs_top",   row_top, 0);
      check("hs_bot",   row_bot, exp_row(6'h08, 6'h08));
      check("hs_addr",  row_addr, 4'd6);
      check("hs_ovf",   err_ovf, 0);
      check("hs_count", row_count, 2);

      // clr_status in the acceptance cycle: count restarts at 1, blank still set
      send_row(64, 6'h10, 6'h00, 6'h00, 6'h00, 4'd8, 1'b0, 1'b1, 1'b1);
      check("clracc_valid", v_k3, 1);
      check("clracc_count", row_count, 1);
      check("clracc_blank", err_blank, 1);
      check("clracc_top",   row_top, exp_row(6'h10, 6'h00));

      // Mid-row reset discards partial row and the held row
      pulses(30, 6'h3F, 6'h3F, 6'h3F, 6'h3F);
      @(negedge clk);
      n_reset = 1'b0;
      repeat (2) @(negedge clk);
      check("mrst_valid", row_valid, 0);
      check("mrst_count", row_count, 0);
      check("mrst_errs",  {err_len, err_ovf, err_blank}, 0);
      check("mrst_top",   row_top, 0);
      n_reset = 1'b1;
      repeat (2) @(negedge clk);
      send_row(64, 6'h04, 6'h00, 6'h00, 6'h00, 4'd11, 1'b1, 1'b0, 1'b0);
      check("mrst_row_valid", v_k3, 1);
      check("mrst_row_top",   row_top, exp_row(6'h04, 6'h00));
      check("mrst_row_bot",   row_bot, 0);
      check("mrst_row_count", row_count, 1);
      check("mrst_row_len",   err_len, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
